// File: rtl/ejection_reduce.sv
// ejection_reduce: per-port ejection FIFOs feeding registered pass-through outputs and a
// round-robin arbitrated three-stage reduction pipeline that accumulates into an indexed table.
module ejection_reduce #(
   parameter int NumPorts        = 7,
   parameter int DataWidth       = 256,
   parameter int FifoDepth       = 4,
   parameter int ReductionBitPos = 254,
   parameter int IndexPos        = 128,
   parameter int IndexWidth      = 8,
   parameter int WeightPos       = 144,
   parameter int WeightWidth     = 8,
   parameter int PayloadLen      = 128,
   parameter int ExpectWidth     = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NumPorts*DataWidth-1:0] in_data,
   input  logic [NumPorts-1:0]           in_pipeline_stall,
   output logic [NumPorts-1:0]           in_avail,
   output logic [NumPorts*DataWidth-1:0] out_data,
   output logic [DataWidth-1:0]          out_reduction,
   input  logic                          cfg_we,
   input  logic [IndexWidth-1:0]         cfg_index,
   input  logic [ExpectWidth-1:0]        cfg_expect
);
   localparam int AddrW    = $clog2(FifoDepth);
   localparam int PortW    = $clog2(NumPorts);
   localparam int TabDepth = 2 ** IndexWidth;
   localparam int EntryW   = 2 * ExpectWidth + WeightWidth + PayloadLen;
   localparam logic [AddrW:0]         PtrOne   = (AddrW + 1)'(32'd1);
   localparam logic [ExpectWidth-1:0] CntOne   = ExpectWidth'(32'd1);
   localparam logic [PortW-1:0]       PortOne  = PortW'(32'd1);
   localparam logic [PortW-1:0]       PortLast = PortW'(NumPorts - 1);

   typedef struct packed {
      logic [ExpectWidth-1:0] exp_n;
      logic [ExpectWidth-1:0] cnt;
      logic [WeightWidth-1:0] wt;
      logic [PayloadLen-1:0]  pl;
   } entry_t;

   logic [DataWidth-1:0]          r_mem [NumPorts][FifoDepth];
   logic [AddrW:0]                r_wptr [NumPorts];
   logic [AddrW:0]                r_rptr [NumPorts];
   logic [DataWidth-1:0]          w_head [NumPorts];
   logic [NumPorts-1:0]           w_empty, w_full, w_push, w_pop, w_pop_pt, w_req;

   logic [PortW-1:0]              r_rr, w_rr_next, w_gnt_idx, w_j;
   logic                          w_gnt_v, w_take;
   logic [DataWidth-1:0]          w_gnt_pkt;

   logic [NumPorts*DataWidth-1:0] r_out_data;
   logic [DataWidth-1:0]          r_out_reduction;

   logic                          r_s1_v, r_s2_v;
   logic [DataWidth-1:0]          r_s1_pkt, r_s2_pkt;
   entry_t                        r_s2_ent;
   entry_t                        r_tab [TabDepth];
   logic [IndexWidth-1:0]         w_s1_idx, w_s2_idx;
   entry_t                        w_s2_rd, w_s3_acc, w_s3_wb, w_cfg_ent;
   logic [ExpectWidth-1:0]        w_s3_need;
   logic                          w_s3_fire, w_s3_we;
   logic [DataWidth-1:0]          w_emit;

   // Per-port FIFO status, push qualification and head classification.
   always_comb begin
      for (int p = 0; p < NumPorts; p++) begin
         w_head[p]   = r_mem[p][r_rptr[p][AddrW-1:0]];
         w_empty[p]  = (r_wptr[p] == r_rptr[p]);
         w_full[p]   = (r_wptr[p][AddrW] != r_rptr[p][AddrW]) &&
                       (r_wptr[p][AddrW-1:0] == r_rptr[p][AddrW-1:0]);
         w_push[p]   = in_data[p*DataWidth + DataWidth - 1] && !in_pipeline_stall[p] && !w_full[p];
         w_pop_pt[p] = !w_empty[p] && !w_head[p][ReductionBitPos];
         w_req[p]    = !w_empty[p] &&  w_head[p][ReductionBitPos];
      end
   end

   // Round-robin search starting at the pointer; first requester wins.
   always_comb begin
      w_gnt_v   = 1'b0;
      w_gnt_idx = r_rr;
      w_gnt_pkt = {DataWidth{1'b0}};
      w_j       = r_rr;
      w_take    = 1'b0;
      for (int i = 0; i < NumPorts; i++) begin
         w_j       = PortW'((int'(r_rr) + i) % NumPorts);
         w_take    = !w_gnt_v && w_req[w_j];
         w_gnt_idx = w_take ? w_j : w_gnt_idx;
         w_gnt_pkt = w_take ? w_head[w_j] : w_gnt_pkt;
         w_gnt_v   = w_gnt_v || w_take;
      end
      if (!w_gnt_v) begin
         w_rr_next = r_rr;
      end else if (w_gnt_idx == PortLast) begin
         w_rr_next = {PortW{1'b0}};
      end else begin
         w_rr_next = w_gnt_idx + PortOne;
      end
   end

   // A port pops for its own pass-through head or when it wins the reduction grant.
   always_comb begin
      for (int p = 0; p < NumPorts; p++) begin
         w_pop[p] = w_pop_pt[p] || (w_gnt_v && (w_gnt_idx == PortW'(p)));
      end
   end

   // FIFO storage; contents need no reset because the pointers gate every read.
   always_ff @(posedge clk) begin
      for (int p = 0; p < NumPorts; p++) begin
         if (w_push[p]) begin
            r_mem[p][r_wptr[p][AddrW-1:0]] <= in_data[p*DataWidth +: DataWidth];
         end
      end
   end

   // FIFO pointers and the registered pass-through ejection.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int p = 0; p < NumPorts; p++) begin
            r_wptr[p] <= {(AddrW + 1){1'b0}};
            r_rptr[p] <= {(AddrW + 1){1'b0}};
         end
         r_out_data <= {(NumPorts * DataWidth){1'b0}};
      end else begin
         for (int p = 0; p < NumPorts; p++) begin
            if (w_push[p]) begin
               r_wptr[p] <= r_wptr[p] + PtrOne;
            end
            if (w_pop[p]) begin
               r_rptr[p] <= r_rptr[p] + PtrOne;
            end
            r_out_data[p*DataWidth +: DataWidth] <= w_pop_pt[p] ? w_head[p] : {DataWidth{1'b0}};
         end
      end
   end

   // S3: accumulate, decide emission, and build the write-back entry.
   always_comb begin
      w_s2_idx     = r_s2_pkt[IndexPos +: IndexWidth];
      w_s3_acc     = r_s2_ent;
      w_s3_acc.cnt = r_s2_ent.cnt + CntOne;
      w_s3_acc.wt  = r_s2_ent.wt + r_s2_pkt[WeightPos +: WeightWidth];
      w_s3_acc.pl  = r_s2_ent.pl + r_s2_pkt[0 +: PayloadLen];
      if (r_s2_ent.exp_n == {ExpectWidth{1'b0}}) begin
         w_s3_need = CntOne;
      end else begin
         w_s3_need = r_s2_ent.exp_n;
      end
      w_s3_fire = (w_s3_acc.cnt >= w_s3_need);
      w_emit = r_s2_pkt;
      w_emit[WeightPos +: WeightWidth] = w_s3_acc.wt;
      w_emit[0 +: PayloadLen]          = w_s3_acc.pl;
      w_emit[DataWidth-1]              = 1'b1;
      if (w_s3_fire) begin
         w_s3_wb       = {EntryW{1'b0}};
         w_s3_wb.exp_n = r_s2_ent.exp_n;
      end else begin
         w_s3_wb = w_s3_acc;
      end
      // A same-cycle configuration of this index overrides the accumulation.
      w_s3_we = r_s2_v && !(cfg_we && (cfg_index == w_s2_idx));
   end

   // S2 table read with forwarding: cfg write first, then the S3 write-back.
   always_comb begin
      w_s1_idx        = r_s1_pkt[IndexPos +: IndexWidth];
      w_cfg_ent       = {EntryW{1'b0}};
      w_cfg_ent.exp_n = cfg_expect;
      if (cfg_we && (cfg_index == w_s1_idx)) begin
         w_s2_rd = w_cfg_ent;
      end else if (r_s2_v && (w_s2_idx == w_s1_idx)) begin
         w_s2_rd = w_s3_wb;
      end else begin
         w_s2_rd = r_tab[w_s1_idx];
      end
   end

   // Reduction pipeline registers, arbitration pointer and reduction output.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr            <= {PortW{1'b0}};
         r_s1_v          <= 1'b0;
         r_s2_v          <= 1'b0;
         r_s1_pkt        <= {DataWidth{1'b0}};
         r_s2_pkt        <= {DataWidth{1'b0}};
         r_s2_ent        <= {EntryW{1'b0}};
         r_out_reduction <= {DataWidth{1'b0}};
      end else begin
         r_rr            <= w_rr_next;
         r_s1_v          <= w_gnt_v;
         r_s1_pkt        <= w_gnt_v ? w_gnt_pkt : {DataWidth{1'b0}};
         r_s2_v          <= r_s1_v;
         r_s2_pkt        <= r_s1_pkt;
         r_s2_ent        <= w_s2_rd;
         r_out_reduction <= (r_s2_v && w_s3_fire) ? w_emit : {DataWidth{1'b0}};
      end
   end

   // Reduction table: S3 write-back and configuration writes never share an index.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < TabDepth; i++) begin
            r_tab[i] <= {EntryW{1'b0}};
         end
      end else begin
         if (w_s3_we) begin
            r_tab[w_s2_idx] <= w_s3_wb;
         end
         if (cfg_we) begin
            r_tab[cfg_index] <= w_cfg_ent;
         end
      end
   end

   assign in_avail      = ~w_full;
   assign out_data      = r_out_data;
   assign out_reduction = r_out_reduction;

endmodule

// File: tb/tb_ejection_reduce.sv
// Bench for ejection_reduce: directed scenarios followed by random traffic, every cycle
// compared with a queue-and-table reference model of the ejection/reduction rules.
module tb_ejection_reduce;
   localparam int NP = 7;
   localparam int DW = 256;
   localparam int FD = 4;

   logic             clk;
   logic             rst;
   logic [NP*DW-1:0] in_data;
   logic [NP-1:0]    in_pipeline_stall;
   logic [NP-1:0]    in_avail;
   logic [NP*DW-1:0] out_data;
   logic [DW-1:0]    out_reduction;
   logic             cfg_we;
   logic [7:0]       cfg_index;
   logic [2:0]       cfg_expect;

   int n_checks = 0;
   int n_pass   = 0;
   int n_emit   = 0;
   logic [DW-1:0] last_red;

   // Reference model: per-port queues (index 0 is the head), table, grant history.
   logic [DW-1:0]  mq [NP][FD];
   int             mlen [NP];
   int             mrr;
   logic [2:0]     t_exp [256];
   logic [2:0]     t_cnt [256];
   logic [7:0]     t_wt  [256];
   logic [127:0]   t_pl  [256];
   logic           pv [2];
   logic [DW-1:0]  pp [2];

   ejection_reduce dut (
      .clk               (clk),
      .rst               (rst),
      .in_data           (in_data),
      .in_pipeline_stall (in_pipeline_stall),
      .in_avail          (in_avail),
      .out_data          (out_data),
      .out_reduction     (out_reduction),
      .cfg_we            (cfg_we),
      .cfg_index         (cfg_index),
      .cfg_expect        (cfg_expect)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic logic [DW-1:0] mk(input logic red, input logic [7:0] idx, input logic [7:0] wt,
                                         input logic [127:0] pl, input logic [127:0] up);
      logic [DW-1:0] p;
      p            = '0;
      p[255]       = 1'b1;
      p[254]       = red;
      p[253:152]   = up[101:0];
      p[151:144]   = wt;
      p[135:128]   = idx;
      p[127:0]     = pl;
      return p;
   endfunction

   task automatic idle();
      in_data           = '0;
      in_pipeline_stall = '0;
      cfg_we            = 1'b0;
      cfg_index         = 8'd0;
      cfg_expect        = 3'd0;
      rst               = 1'b0;
   endtask

   task automatic model_clear();
      for (int p = 0; p < NP; p++) mlen[p] = 0;
      mrr = 0;
      for (int i = 0; i < 256; i++) begin
         t_exp[i] = 3'd0; t_cnt[i] = 3'd0; t_wt[i] = 8'd0; t_pl[i] = 128'd0;
      end
      for (int k = 0; k < 2; k++) begin
         pv[k] = 1'b0; pp[k] = '0;
      end
   endtask

   task automatic pop(input int p);
      for (int k = 0; k < FD - 1; k++) mq[p][k] = mq[p][k+1];
      mlen[p] = mlen[p] - 1;
   endtask

   // One clock cycle: inputs are already driven; predict, clock, then compare.
   task automatic step();
      logic [DW-1:0] nod [NP];
      logic [DW-1:0] nred, gp, s, slice;
      logic [NP-1:0] full, exp_av;
      int            g, q, ix;
      logic [2:0]    c, need;
      logic [7:0]    w;
      logic [127:0]  pl;
      for (int p = 0; p < NP; p++) exp_av[p] = (mlen[p] < FD);
      chk("in_avail", in_avail, exp_av);
      nred = '0;
      gp   = '0;
      g    = -1;
      for (int p = 0; p < NP; p++) nod[p] = '0;
      if (rst) begin
         model_clear();
      end else begin
         for (int p = 0; p < NP; p++) full[p] = (mlen[p] == FD);
         for (int i = 0; i < NP; i++) begin
            q = (mrr + i) % NP;
            if (g < 0 && mlen[q] > 0 && mq[q][0][254]) g = q;
         end
         if (g >= 0) gp = mq[g][0];
         for (int p = 0; p < NP; p++)
            if (mlen[p] > 0 && !mq[p][0][254]) nod[p] = mq[p][0];
         for (int p = 0; p < NP; p++)
            if (nod[p][255] || p == g) pop(p);
         for (int p = 0; p < NP; p++) begin
            slice = in_data[p*DW +: DW];
            if (slice[255] && !in_pipeline_stall[p] && !full[p]) begin
               mq[p][mlen[p]] = slice;
               mlen[p] = mlen[p] + 1;
            end
         end
         if (g >= 0) mrr = (g + 1) % NP;
         // The packet granted two cycles ago completes now; cfg is applied after it.
         if (pv[1]) begin
            s    = pp[1];
            ix   = int'(s[135:128]);
            c    = t_cnt[ix] + 3'd1;
            w    = t_wt[ix] + s[151:144];
            pl   = t_pl[ix] + s[127:0];
            need = (t_exp[ix] == 3'd0) ? 3'd1 : t_exp[ix];
            if (c >= need) begin
               nred = s;
               nred[151:144] = w;
               nred[127:0]   = pl;
               t_cnt[ix] = 3'd0; t_wt[ix] = 8'd0; t_pl[ix] = 128'd0;
            end else begin
               t_cnt[ix] = c; t_wt[ix] = w; t_pl[ix] = pl;
            end
         end
         if (cfg_we) begin
            t_exp[cfg_index] = cfg_expect;
            t_cnt[cfg_index] = 3'd0; t_wt[cfg_index] = 8'd0; t_pl[cfg_index] = 128'd0;
         end
         pv[1] = pv[0];
         pp[1] = pp[0];
         pv[0] = (g >= 0);
         pp[0] = gp;
      end
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++)
         chk($sformatf("out_data[%0d]", p), out_data[p*DW +: DW], nod[p]);
      chk("out_reduction", out_reduction, nred);
      if (out_reduction[255]) begin
         n_emit++;
         last_red = out_reduction;
      end
      @(negedge clk);
   endtask

   initial begin
      logic [DW-1:0]  pkt;
      logic [127:0]   rpl;
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      model_clear();
      chk("reset_in_avail", in_avail, 256'h7f);
      chk("reset_out_reduction", out_reduction, '0);
      for (int p = 0; p < NP; p++) chk("reset_out_data", out_data[p*DW +: DW], '0);
      @(negedge clk);
      idle();

      // Pass-through on port 3: visible two edges after it is driven.
      pkt = mk(1'b0, 8'd0, 8'd0, 128'h1234_5678, 128'habc);
      in_data[3*DW +: DW] = pkt;
      step();
      idle();
      step();
      chk("ptx_port3", out_data[3*DW +: DW], pkt);
      step();

      // Three-way reduction on index 5 with expect 3.
      cfg_we = 1'b1; cfg_index = 8'd5; cfg_expect = 3'd3;
      step();
      idle();
      in_data[0*DW +: DW] = mk(1'b1, 8'd5, 8'd1, 128'd10, 128'd0);
      in_data[1*DW +: DW] = mk(1'b1, 8'd5, 8'd2, 128'd20, 128'd0);
      in_data[2*DW +: DW] = mk(1'b1, 8'd5, 8'd3, 128'd30, 128'd0);
      step();
      idle();
      n_emit = 0;
      repeat (6) step();
      chk("red3_emits", 256'(n_emit), 256'd1);
      chk("red3_weight", 256'(last_red[151:144]), 256'd6);
      chk("red3_payload", 256'(last_red[127:0]), 256'd60);
      chk("red3_index", 256'(last_red[135:128]), 256'd5);

      // Back-to-back packets on the same index exercise forwarding.
      cfg_we = 1'b1; cfg_index = 8'd9; cfg_expect = 3'd2;
      step();
      idle();
      in_data[4*DW +: DW] = mk(1'b1, 8'd9, 8'd1, 128'd7, 128'd0);
      step();
      in_data[4*DW +: DW] = mk(1'b1, 8'd9, 8'd1, 128'd8, 128'd0);
      n_emit = 0;
      step();
      idle();
      repeat (5) step();
      chk("fwd_emits", 256'(n_emit), 256'd1);
      chk("fwd_payload", 256'(last_red[127:0]), 256'd15);

      // Backpressure: port 1 fills while ports 0 and 2 compete for grants.
      for (int k = 0; k < 6; k++) begin
         for (int p = 0; p < 3; p++)
            in_data[p*DW +: DW] = mk(1'b1, 8'd20, 8'(k), 128'(p * 100 + k), 128'd0);
         step();
         if (k == 4) chk("bp_avail1_full", 256'(in_avail[1]), 256'd0);
      end
      idle();
      repeat (20) step();

      // Payload accumulator wrap.
      cfg_we = 1'b1; cfg_index = 8'd7; cfg_expect = 3'd2;
      step();
      idle();
      in_data[5*DW +: DW] = mk(1'b1, 8'd7, 8'd0, {128{1'b1}}, 128'd0);
      step();
      in_data[5*DW +: DW] = mk(1'b1, 8'd7, 8'd0, 128'd2, 128'd0);
      n_emit = 0;
      step();
      idle();
      repeat (5) step();
      chk("wrap_emits", 256'(n_emit), 256'd1);
      chk("wrap_payload", 256'(last_red[127:0]), 256'd1);

      // Reset while a reduction packet sits in S2 and another waits in a FIFO.
      in_data[6*DW +: DW] = mk(1'b1, 8'd30, 8'd5, 128'd99, 128'd0);
      step();
      idle();
      step();
      in_data[0*DW +: DW] = mk(1'b1, 8'd31, 8'd1, 128'd1, 128'd0);
      step();
      idle();
      rst = 1'b1;
      n_emit = 0;
      step();
      idle();
      chk("rst_mid_avail", in_avail, 256'h7f);
      chk("rst_mid_red", out_reduction, '0);
      repeat (5) step();
      chk("rst_mid_emits", 256'(n_emit), 256'd0);

      // Random traffic with a small index set so collisions and forwarding are common.
      for (int cyc = 0; cyc < 400; cyc++) begin
         idle();
         for (int p = 0; p < NP; p++) begin
            if ($urandom_range(0, 1) == 1) begin
               if ($urandom_range(0, 3) == 0) rpl = ~128'd0 - 128'($urandom_range(0, 3));
               else rpl = {$urandom, $urandom, $urandom, $urandom};
               in_data[p*DW +: DW] = mk(1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)),
                                        8'($urandom), rpl, {$urandom, $urandom, $urandom, $urandom});
            end
            in_pipeline_stall[p] = ($urandom_range(0, 7) == 0);
         end
         if ($urandom_range(0, 7) == 0) begin
            cfg_we     = 1'b1;
            cfg_index  = 8'($urandom_range(0, 3));
            cfg_expect = 3'($urandom_range(0, 7));
         end
         if ($urandom_range(0, 149) == 0) rst = 1'b1;
         step();
      end
      idle();
      repeat (6) step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/ejection_reduce.md
EJECTION_REDUCE -- requirements
Module: ejection_reduce

Interface
REQ-001 SHALL have parameter NumPorts, default 7, giving the number of ingress channels (2..8).
REQ-002 SHALL have parameter DataWidth, default 256, giving the packet width; bit DataWidth-1 is the valid flag.
REQ-003 SHALL have parameter FifoDepth, default 4, giving per-port FIFO entries (power of 2, at least 2).
REQ-004 SHALL have parameters ReductionBitPos=254, IndexPos=128, IndexWidth=8, WeightPos=144, WeightWidth=8, PayloadLen=128, and ExpectWidth=3, with the field meanings named.
REQ-005 SHALL have the following ports, each given as name, direction, width, meaning:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  NumPorts*DataWidth  ingress packets; port p occupies slice p.
- in_pipeline_stall  in  NumPorts  upstream stall per port.
- in_avail  out  NumPorts  per-port FIFO not full.
- out_data  out  NumPorts*DataWidth  registered non-reduction ejections per port.
- out_reduction  out  DataWidth  registered completed reduction result.
- cfg_we  in  1  table configuration strobe.
- cfg_index  in  IndexWidth  table entry to configure.
- cfg_expect  in  ExpectWidth  fan-in count for that entry.

Function
REQ-006 SHALL push in_data slice p into FIFO p when its valid bit=1, in_pipeline_stall[p]=0, and FIFO p is not full; the push SHALL be silently ignored when the FIFO is full.
REQ-007 SHALL pop a non-empty head whose ReductionBitPos=0 every cycle, registering it to out_data slice p one cycle later; otherwise slice p SHALL be 0.
REQ-008 SHALL arbitrate among non-empty heads with ReductionBitPos=1 using round-robin, granting at most one per cycle and popping only the granted FIFO.
REQ-009 After a grant, the round-robin pointer SHALL move to the port after the granted one; with no grant, the pointer SHALL hold.
REQ-010 SHALL keep a table of 2^IndexWidth entries, each holding {expect, count, weight accumulator, payload accumulator}.
REQ-011 SHALL run the reduction path as three stages:
- S1: register the granted packet.
- S2: read the table entry at the packet IndexPos field.
- S3: accumulate, write back, and optionally emit.
A packet granted in cycle t SHALL therefore reach out_reduction at t+3.
REQ-012 In S3, the new values SHALL be:
- count = count+1
- weight = weight + packet weight
- payload = payload + packet payload
All additions SHALL wrap modulo their field width.
REQ-013 When the new count >= expect (expect=0 counts as 1), the block SHALL:
- drive out_reduction with the S3 packet bits above WeightPos+WeightWidth, the accumulated weight, the packet index, and the accumulated payload, with the valid bit set;
- write back count=0 and both accumulators=0, keeping expect.
REQ-014 When the new count < expect, out_reduction SHALL be 0 and the updated entry SHALL be written back.
REQ-015 When S2 and S3 hold the same index in the same cycle, S2 SHALL use the S3 write-back value (forwarding), so back-to-back same-index packets accumulate exactly once each.
REQ-016 cfg_we SHALL write expect=cfg_expect and clear count and both accumulators at cfg_index.
REQ-017 When cfg_we and an S3 write-back target the same index in the same cycle, the cfg write SHALL win and the S3 write-back SHALL be dropped; out_reduction still follows REQ-013/014.
REQ-018 A cfg write that matches the S2 index SHALL be forwarded to S2.
REQ-019 Pass-through ejection and reduction processing SHALL be independent; up to NumPorts pass-through packets plus one reduction grant SHALL proceed in the same cycle.

Reset
REQ-020 While rst=1, at the clock edge the block SHALL:
- empty all FIFOs (in_avail all 1 after reset);
- set out_data=0 and out_reduction=0;
- invalidate pipeline stages S1-S3;
- set the round-robin pointer to port 0;
- clear every table entry (expect, count, accumulators) to 0.
REQ-021 Reset asserted mid-operation SHALL discard all in-flight packets with no emission on the following cycle.

Verification
REQ-022 Pass-through: non-reduction valid packet on port 3 at cycle t -> equal value on out_data slice 3 at t+2 (push at t, pop and register at t+1); all other slices 0.
REQ-023 Reduction, expect=3: cfg index 5. Three packets with weights 1,2,3 and payloads 10,20,30 arrive on ports 0,1,2 in the same cycle -> grants in order 0,1,2 on consecutive cycles; out_reduction is 0 twice, then weight=6, payload=60, index=5; entry 5 count then reads 0.
REQ-024 Forwarding: expect=2, index 9, two packets on port 4 in consecutive cycles with payloads 7 and 8 -> one emission with payload 15.
REQ-025 Backpressure: fill FIFO 1 with FifoDepth reduction packets while ports 0 and 2 also hold reduction heads -> in_avail[1]=0, extra pushes dropped, round-robin alternates 0,1,2.
REQ-026 Wrap: payload accumulator at 2^128-1 plus packet payload 2 with count reaching expect -> out_reduction payload=1.
REQ-027 Reset mid-flight: assert rst with a packet in S2 -> out_reduction=0 and all in_avail=1 after release.
